// File: rtl/dlsc_pcie_s6_tlp_encoder.sv
// TX TLP builder for the Spartan-6 PCIe 32-bit AXI stream: header DW0..DW3 then payload.
// Optional payload length checking/draining: DLSC_PCIE_S6_TLP_ENCODER_PL_CHECK_EN.
module dlsc_pcie_s6_tlp_encoder #(
  parameter logic [1:0] ATTR = 2'b00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cfg_id,
  output logic        tlp_ready,
  input  logic        tlp_valid,
  input  logic        tlp_mem_read,
  input  logic        tlp_mem_write,
  input  logic        tlp_cpl,
  input  logic        tlp_cpl_data,
  input  logic [2:0]  tlp_tc,
  input  logic [9:0]  tlp_length,
  input  logic [15:0] tlp_dst,
  input  logic [7:0]  req_tag,
  input  logic [3:0]  req_be_last,
  input  logic [3:0]  req_be_first,
  input  logic [61:0] req_addr,
  input  logic [2:0]  cpl_status,
  input  logic        cpl_bcm,
  input  logic [11:0] cpl_bytes,
  input  logic [7:0]  cpl_tag,
  input  logic [6:0]  cpl_addr,
  output logic        pl_ready,
  input  logic        pl_valid,
  input  logic        pl_last,
  input  logic [31:0] pl_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic        tx_last,
  output logic [31:0] tx_data,
  output logic        tx_dsc,
  output logic        err_cmd
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR1, ST_HDR2, ST_HDR3, ST_PAYLOAD, ST_DRAIN
  } st_t;

  st_t         st_q, st_d;
  logic        cpl_q, cpl_d, dw4_q, dw4_d, dat_q, dat_d;
  logic [7:0]  tag_q, tag_d, be_q, be_d, ctag_q, ctag_d;
  logic [61:0] addr_q, addr_d;
  logic [2:0]  sts_q, sts_d;
  logic        bcm_q, bcm_d;
  logic [11:0] bytes_q, bytes_d;
  logic [15:0] dst_q, dst_d;
  logic [6:0]  caddr_q, caddr_d;
  logic [10:0] cnt_q, cnt_d;
  logic        tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
  logic        tx_dsc_q, tx_dsc_d, err_q, err_d;
  logic [31:0] tx_data_q, tx_data_d;

  logic        free, legal, in_4dw, in_dat, cnt_end;
  logic [9:0]  in_len;
  logic [31:0] dw0;

`ifndef DLSC_PCIE_S6_TLP_ENCODER_PL_CHECK_EN
  logic unused_pl_last;
  assign unused_pl_last = pl_last;
`endif

  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign tx_data  = tx_data_q;
  assign tx_dsc   = tx_dsc_q;
  assign err_cmd  = err_q;

  assign free    = !tx_valid_q || tx_ready;
  assign legal   = {tlp_mem_read, tlp_mem_write, tlp_cpl}
                   inside {3'b100, 3'b010, 3'b001};
  assign in_4dw  = !tlp_cpl && (|req_addr[61:30]);
  assign in_dat  = tlp_mem_write || (tlp_cpl && tlp_cpl_data);
  assign in_len  = (tlp_cpl && !tlp_cpl_data) ? 10'd0 : tlp_length;
  assign cnt_end = (cnt_q == 11'd1);
  assign dw0 = {1'b0, in_dat, in_4dw,
                tlp_cpl ? 5'b01010 : 5'b00000,
                1'b0, tlp_tc, 4'b0, 2'b00, ATTR, 2'b00, in_len};

  always_comb begin
    st_d = st_q;
    cpl_d = cpl_q; dw4_d = dw4_q; dat_d = dat_q;
    tag_d = tag_q; be_d = be_q; ctag_d = ctag_q;
    addr_d = addr_q; sts_d = sts_q; bcm_d = bcm_q;
    bytes_d = bytes_q; dst_d = dst_q; caddr_d = caddr_q;
    cnt_d = cnt_q;
    tx_valid_d = tx_valid_q && !tx_ready;
    tx_last_d = tx_last_q;
    tx_dsc_d = tx_dsc_q;
    tx_data_d = tx_data_q;
    err_d = 1'b0;
    tlp_ready = 1'b0;
    pl_ready = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        tlp_ready = free;
        if (tlp_valid && free) begin
          if (legal) begin
            cpl_d = tlp_cpl; dw4_d = in_4dw; dat_d = in_dat;
            tag_d = req_tag; be_d = {req_be_last, req_be_first};
            addr_d = req_addr; sts_d = cpl_status; bcm_d = cpl_bcm;
            bytes_d = cpl_bytes; dst_d = tlp_dst;
            ctag_d = cpl_tag; caddr_d = cpl_addr;
            cnt_d = {tlp_length == 10'd0, tlp_length};
            tx_valid_d = 1'b1; tx_last_d = 1'b0;
            tx_dsc_d = 1'b0; tx_data_d = dw0;
            st_d = ST_HDR1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HDR1: if (free) begin
        tx_valid_d = 1'b1; tx_last_d = 1'b0; tx_dsc_d = 1'b0;
        tx_data_d = cpl_q ? {cfg_id, sts_q, bcm_q, bytes_q}
                          : {cfg_id, tag_q, be_q};
        st_d = ST_HDR2;
      end
      ST_HDR2: if (free) begin
        tx_valid_d = 1'b1; tx_dsc_d = 1'b0;
        tx_last_d = !dw4_q && !dat_q;
        if (cpl_q)      tx_data_d = {dst_q, ctag_q, 1'b0, caddr_q};
        else if (dw4_q) tx_data_d = addr_q[61:30];
        else            tx_data_d = {addr_q[29:0], 2'b00};
        st_d = dw4_q ? ST_HDR3 : (dat_q ? ST_PAYLOAD : ST_IDLE);
      end
      ST_HDR3: if (free) begin
        tx_valid_d = 1'b1; tx_dsc_d = 1'b0;
        tx_last_d = !dat_q;
        tx_data_d = {addr_q[29:0], 2'b00};
        st_d = dat_q ? ST_PAYLOAD : ST_IDLE;
      end
      ST_PAYLOAD: begin
        pl_ready = free;
        if (pl_valid && free) begin
          tx_valid_d = 1'b1; tx_dsc_d = 1'b0;
          tx_data_d = pl_data;
          tx_last_d = cnt_end;
          cnt_d = cnt_q - 11'd1;
          if (cnt_end) st_d = ST_IDLE;
`ifdef DLSC_PCIE_S6_TLP_ENCODER_PL_CHECK_EN
          // short payload aborts the TLP; long payload drains the excess
          if (pl_last && !cnt_end) begin
            tx_last_d = 1'b1; tx_dsc_d = 1'b1;
            err_d = 1'b1; st_d = ST_IDLE;
          end else if (!pl_last && cnt_end) begin
            err_d = 1'b1; st_d = ST_DRAIN;
          end
`endif
        end
      end
`ifdef DLSC_PCIE_S6_TLP_ENCODER_PL_CHECK_EN
      ST_DRAIN: begin
        pl_ready = 1'b1;
        if (pl_valid && pl_last) st_d = ST_IDLE;
      end
`endif
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= ST_IDLE;
      cpl_q <= 1'b0; dw4_q <= 1'b0; dat_q <= 1'b0;
      tag_q <= '0; be_q <= '0; ctag_q <= '0;
      addr_q <= '0; sts_q <= '0; bcm_q <= 1'b0;
      bytes_q <= '0; dst_q <= '0; caddr_q <= '0;
      cnt_q <= '0;
      tx_valid_q <= 1'b0; tx_last_q <= 1'b0;
      tx_dsc_q <= 1'b0; tx_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cpl_q <= cpl_d; dw4_q <= dw4_d; dat_q <= dat_d;
      tag_q <= tag_d; be_q <= be_d; ctag_q <= ctag_d;
      addr_q <= addr_d; sts_q <= sts_d; bcm_q <= bcm_d;
      bytes_q <= bytes_d; dst_q <= dst_d; caddr_q <= caddr_d;
      cnt_q <= cnt_d;
      tx_valid_q <= tx_valid_d; tx_last_q <= tx_last_d;
      tx_dsc_q <= tx_dsc_d; tx_data_q <= tx_data_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_dlsc_pcie_s6_tlp_encoder.sv
// Directed self-checking bench for dlsc_pcie_s6_tlp_encoder.
// Checks header/payload words, stalls, back-to-back, illegal commands, reset.
module tb_dlsc_pcie_s6_tlp_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_id = 16'h0100;
  logic        tlp_ready;
  logic        tlp_valid = 1'b0;
  logic        tlp_mem_read = 1'b0, tlp_mem_write = 1'b0;
  logic        tlp_cpl = 1'b0, tlp_cpl_data = 1'b0;
  logic [2:0]  tlp_tc = '0;
  logic [9:0]  tlp_length = '0;
  logic [15:0] tlp_dst = '0;
  logic [7:0]  req_tag = '0;
  logic [3:0]  req_be_last = '0, req_be_first = '0;
  logic [61:0] req_addr = '0;
  logic [2:0]  cpl_status = '0;
  logic        cpl_bcm = 1'b0;
  logic [11:0] cpl_bytes = '0;
  logic [7:0]  cpl_tag = '0;
  logic [6:0]  cpl_addr = '0;
  logic        pl_ready;
  logic        pl_valid = 1'b0, pl_last = 1'b0;
  logic [31:0] pl_data = '0;
  logic        tx_ready = 1'b1;
  logic        tx_valid, tx_last, tx_dsc, err_cmd;
  logic [31:0] tx_data;

  dlsc_pcie_s6_tlp_encoder dut (
    .clk(clk), .rst_n(rst_n), .cfg_id(cfg_id),
    .tlp_ready(tlp_ready), .tlp_valid(tlp_valid),
    .tlp_mem_read(tlp_mem_read), .tlp_mem_write(tlp_mem_write),
    .tlp_cpl(tlp_cpl), .tlp_cpl_data(tlp_cpl_data),
    .tlp_tc(tlp_tc), .tlp_length(tlp_length), .tlp_dst(tlp_dst),
    .req_tag(req_tag), .req_be_last(req_be_last),
    .req_be_first(req_be_first), .req_addr(req_addr),
    .cpl_status(cpl_status), .cpl_bcm(cpl_bcm),
    .cpl_bytes(cpl_bytes), .cpl_tag(cpl_tag), .cpl_addr(cpl_addr),
    .pl_ready(pl_ready), .pl_valid(pl_valid), .pl_last(pl_last),
    .pl_data(pl_data), .tx_ready(tx_ready), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_data(tx_data), .tx_dsc(tx_dsc),
    .err_cmd(err_cmd)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, err_cnt = 0, hold_err = 0;
  int acc_cyc = 0;
  bit toggle = 1'b0;
  logic [33:0] q[$];
  logic [33:0] eq[$];
  logic [32:0] plq[$];
  logic        stalled = 1'b0;
  logic [31:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // output monitor: captures {dsc,last,data} of every accepted word
  always @(posedge clk) begin
    if (tx_valid && tx_ready) q.push_back({tx_dsc, tx_last, tx_data});
    if (err_cmd) err_cnt++;
    if (stalled && tx_valid && tx_data !== held) hold_err++;
    stalled = tx_valid && !tx_ready;
    held = tx_data;
    if (pl_valid && pl_ready && plq.size() > 0) void'(plq.pop_front());
  end

  always @(negedge clk) begin
    tx_ready = toggle ? !tx_ready : 1'b1;
    pl_valid = plq.size() > 0;
    if (plq.size() > 0) {pl_last, pl_data} = plq[0];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ew(input logic [31:0] d,
                             input logic l = 1'b0,
                             input logic s = 1'b0);
    eq.push_back({s, l, d});
  endfunction

  task automatic chk_stream(input string tag, input int base);
    int n;
    n = eq.size();
    for (int i = 0; i < 300 && q.size() < base + n; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk({tag, "_cnt"}, 64'(q.size() - base), 64'(n));
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_w%0d", tag, i),
          (base + i < q.size()) ? 64'(q[base + i]) : 64'hx,
          64'(eq[i]));
    eq.delete();
  endtask

  task automatic go();
    bit done;
    done = 1'b0;
    tlp_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (tlp_ready) begin
        acc_cyc = cyc;
        done = 1'b1;
      end
      @(negedge clk);
    end
    tlp_valid = 1'b0;
    if (!done) chk("accept_timeout", 64'(tlp_ready), 64'd1);
  endtask

  task automatic mem(input logic wr, input logic [61:0] a,
                     input logic [9:0] len, input logic [7:0] tag);
    tlp_mem_read = !wr; tlp_mem_write = wr;
    tlp_cpl = 1'b0; tlp_cpl_data = 1'b0;
    tlp_length = len; req_addr = a; req_tag = tag;
    req_be_first = 4'hF;
    req_be_last = (len == 10'd1) ? 4'h0 : 4'hF;
  endtask

  int base, e0, c1;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(tx_valid), 64'd0);
    chk("rst_last", 64'(tx_last), 64'd0);
    chk("rst_data", 64'(tx_data), 64'd0);
    chk("rst_err", 64'(err_cmd), 64'd0);
    chk("rst_dsc", 64'(tx_dsc), 64'd0);
    chk("rst_plrdy", 64'(pl_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_tlprdy", 64'(tlp_ready), 64'd1);

    // MRd 3DW
    base = q.size();
    mem(1'b0, 62'h048D159E, 10'd1, 8'h05);
    go();
    ew(32'h00000001); ew(32'h0100050F); ew(32'h12345678, 1'b1);
    chk_stream("mrd", base);

    // MWr 4DW
    base = q.size();
    mem(1'b1, 62'h40000004, 10'd2, 8'h11);
    plq.push_back({1'b0, 32'hAAAA0001});
    plq.push_back({1'b1, 32'hBBBB0002});
    go();
    ew(32'h60000002); ew(32'h010011FF); ew(32'h00000001);
    ew(32'h00000010); ew(32'hAAAA0001); ew(32'hBBBB0002, 1'b1);
    chk_stream("mwr4", base);

    // CplD
    base = q.size();
    tlp_mem_read = 1'b0; tlp_mem_write = 1'b0;
    tlp_cpl = 1'b1; tlp_cpl_data = 1'b1; tlp_length = 10'd1;
    cpl_status = 3'd0; cpl_bcm = 1'b0; cpl_bytes = 12'd4;
    tlp_dst = 16'h0200; cpl_tag = 8'h07; cpl_addr = 7'h04;
    plq.push_back({1'b1, 32'hDEADBEEF});
    go();
    ew(32'h4A000001); ew(32'h01000004); ew(32'h02000704);
    ew(32'hDEADBEEF, 1'b1);
    chk_stream("cpld", base);

    // stalled MWr 3DW len 4
    base = q.size();
    toggle = 1'b1;
    mem(1'b1, 62'h10, 10'd4, 8'h22);
    for (int i = 1; i <= 4; i++)
      plq.push_back({i == 4, {8{4'(i)}}});
    go();
    ew(32'h40000004); ew(32'h010022FF); ew(32'h00000040);
    ew(32'h11111111); ew(32'h22222222); ew(32'h33333333);
    ew(32'h44444444, 1'b1);
    chk_stream("stall", base);
    toggle = 1'b0;
    @(negedge clk);
    chk("stall_hold", 64'(hold_err), 64'd0);

    // back-to-back MRd pair
    base = q.size();
    mem(1'b0, 62'h1, 10'd1, 8'h0A);
    go();
    c1 = acc_cyc;
    mem(1'b0, 62'h2, 10'd1, 8'h0B);
    go();
    chk("b2b_gap", 64'(acc_cyc - c1), 64'd3);
    ew(32'h00000001); ew(32'h01000A0F); ew(32'h00000004, 1'b1);
    ew(32'h00000001); ew(32'h01000B0F); ew(32'h00000008, 1'b1);
    chk_stream("b2b", base);

    // illegal command
    base = q.size();
    e0 = err_cnt;
    tlp_mem_read = 1'b1; tlp_mem_write = 1'b1; tlp_cpl = 1'b0;
    go();
    repeat (5) @(negedge clk);
    chk("ill_err", 64'(err_cnt - e0), 64'd1);
    chk("ill_tx", 64'(q.size() - base), 64'd0);

    // reset mid-payload
    mem(1'b1, 62'h20, 10'd4, 8'h33);
    plq.push_back({1'b0, 32'h5A5A5A5A});
    go();
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 64'(tx_valid), 64'd0);
    chk("rstmid_last", 64'(tx_last), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = q.size();
    mem(1'b0, 62'h40, 10'd1, 8'h44);
    go();
    ew(32'h00000001); ew(32'h0100440F); ew(32'h00000100, 1'b1);
    chk_stream("postrst", base);

`ifdef DLSC_PCIE_S6_TLP_ENCODER_PL_CHECK_EN
    // early pl_last
    base = q.size();
    e0 = err_cnt;
    mem(1'b1, 62'h30, 10'd4, 8'h55);
    plq.push_back({1'b0, 32'hC0C00000});
    plq.push_back({1'b1, 32'hC0C00001});
    go();
    ew(32'h40000004); ew(32'h010055FF); ew(32'h000000C0);
    ew(32'hC0C00000); ew(32'hC0C00001, 1'b1, 1'b1);
    chk_stream("early", base);
    chk("early_err", 64'(err_cnt - e0), 64'd1);

    // late pl_last: excess drained
    base = q.size();
    e0 = err_cnt;
    mem(1'b1, 62'h31, 10'd2, 8'h66);
    for (int i = 0; i < 4; i++)
      plq.push_back({i == 3, 32'hD0D00000 | 32'(i)});
    go();
    ew(32'h40000002); ew(32'h010066FF); ew(32'h000000C4);
    ew(32'hD0D00000); ew(32'hD0D00001, 1'b1);
    chk_stream("late", base);
    chk("late_err", 64'(err_cnt - e0), 64'd1);
    chk("late_drain", 64'(plq.size()), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
